loopback_pattern_gen: RTL
=========================

Name: loopback_pattern_gen

Overview:
- Parametrised successor to the 8-bit free-running counter data source that feeds the HPIO TX fabric-data port in the loopback benches.
- Generates a selectable test pattern with programmable burst length, a valid/ready handshake toward the TX serializer wrapper, and single-word error injection.
- Sits between the test sequencer and the HPIO TX data input. The matching RX-side checker recomputes the same sequence.

Parameters:
- DATA_W, 8, output word width; must be ≥ 8.
- LEN_W, 16, width of burst_len and word_cnt.
- PRBS7_SEED, 7'h7F, LFSR reload value for PRBS7; must be nonzero.
- PRBS15_SEED, 15'h7FFF, LFSR reload value for PRBS15; must be nonzero.

Ports:
- clk  in  1  fabric data clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a burst from IDLE.
- stop  in  1  level; abort the burst.
- mode  in  3  0 counter, 1 PRBS7, 2 PRBS15, 3 walking-one, 4 fixed; 5-7 treated as counter.
- fixed_val  in  DATA_W  word used in fixed mode.
- burst_len  in  LEN_W  words per burst; 0 means continuous.
- inject_err  in  1  pulse; corrupt the next accepted word.
- out_data  out  DATA_W  pattern word.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts the word.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse at normal burst completion.
- word_cnt  out  LEN_W  words accepted in the current/last burst; saturates at all-ones.

Behaviour:
- Reset (async, rst_n=0): state IDLE; out_data=0, out_valid=0, busy=0, done=0, word_cnt=0; LFSRs reload their seeds; err_pend=0.
- Define "accept" = out_valid & out_ready in the same cycle.
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN when start=1 and stop=0.
  - Same edge: latch mode, fixed_val and burst_len; clear word_cnt; reset the generator.
  - Cycle after start, out_valid=1 and out_data holds the first word (1-cycle latency).
- RUN:
  - out_valid=1.
  - On accept, out_data advances to the next word on the next edge and word_cnt increments.
  - Without accept, out_data and out_valid hold stable (no drop, no skip).
- RUN -> DONE on an accept where burst_len≠0 and word_cnt==burst_len-1. In DONE: out_valid=0, done=1 for one cycle, then -> IDLE. word_cnt keeps its final value until the next start.
- stop=1 in RUN: -> IDLE on the next edge, out_valid=0, no done pulse. An accept in the stop cycle still counts.
- start while RUN or DONE is ignored. mode, fixed_val and burst_len changes during RUN are ignored (latched values only).
- Generator first word / next word:
  - counter: first 0, then +1 mod 2^DATA_W (wraps from all-ones to 0).
  - walking-one: first 1, then rotate left by 1; the MSB wraps to bit 0.
  - fixed: fixed_val on every word.
  - PRBS7: polynomial x^7+x^6+1, shift left, feedback fb = s[6]^s[5] enters s[0]. Each word steps the LFSR DATA_W times; the k-th fb bit of the word goes to out_data[DATA_W-1-k]. Must be implemented as a single-cycle parallel step.
  - PRBS15: same scheme with x^15+x^14+1, fb = s[14]^s[13].
- Error injection:
  - inject_err sets err_pend (any state).
  - The word currently presented has out_data[0] inverted while err_pend=1 in RUN. err_pend clears on that word's accept.
  - The generator sequence itself is not altered.
  - inject_err pulses while err_pend=1 merge into one error.
- start and stop in the same IDLE cycle: stay in IDLE.

Test Plan:
- Counter, DATA_W=8, burst_len=300, out_ready=1: start -> words 0x00..0xFF, 0x00..0x2B; word_cnt=300; done pulses exactly once; out_valid low afterwards.
- PRBS7, seed 7'h7F, DATA_W=8, burst_len=0: start -> first words 0x02, 0x0C; the sequence matches the reference model for 10000 words with no end.
- Walking-one, out_ready toggling 1,0,0,1 repeatedly: out_data 0x01, 0x02, 0x04, … 0x80, 0x01; each word holds stable while out_ready=0; word_cnt counts accepts only.
- Counter, continuous: stop asserted after 5 accepts -> IDLE next cycle; done=0; word_cnt=5. A new start restarts at 0x00.
- Fixed 0xA5, inject_err during the 3rd word -> accepted words A5, A5, A4, A5.
- rst_n pulled low mid-burst (asynchronous, between edges) -> outputs zero immediately. After release, the bench issues start with mode PRBS7 -> first word 0x02 (seed reloaded).

Source files
------------

// File: rtl/loopback_pattern_gen.sv
// loopback_pattern_gen: burst test-pattern source (counter, PRBS7, PRBS15, walking-one, fixed)
// with a valid/ready handshake toward the TX serializer and single-word error injection.
module loopback_pattern_gen #(
   parameter int         DATA_W      = 8,
   parameter int         LEN_W       = 16,
   parameter logic [6:0]  PRBS7_SEED  = 7'h7F,
   parameter logic [14:0] PRBS15_SEED = 15'h7FFF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              stop,
   input  logic [2:0]        mode,
   input  logic [DATA_W-1:0] fixed_val,
   input  logic [LEN_W-1:0]  burst_len,
   input  logic              inject_err,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic              done,
   output logic [LEN_W-1:0]  word_cnt
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state_q, state_d;
   logic [DATA_W-1:0] data_q, data_d, fix_q, fix_d, w7, w15, nxt;
   logic [6:0] p7_q, p7_d;
   logic [14:0] p15_q, p15_d;
   logic [LEN_W-1:0] len_q, len_d, cnt_q, cnt_d;
   logic [2:0] mode_q, mode_d, m;
   logic err_q, err_d, run, go, acc, step;

   assign run  = state_q == RUN;
   assign go   = state_q == IDLE && start && !stop;
   assign acc  = run && out_ready;
   assign step = go || acc;

   // DATA_W serial LFSR shifts unrolled into one cycle; the first feedback bit lands in the MSB.
   always_comb begin
      p7_d  = go ? PRBS7_SEED : p7_q;
      p15_d = go ? PRBS15_SEED : p15_q;
      w7    = '0;
      w15   = '0;
      for (int k = 0; k < DATA_W; k++) begin
         w7[DATA_W-1-k]  = p7_d[6] ^ p7_d[5];
         p7_d            = {p7_d[5:0], w7[DATA_W-1-k]};
         w15[DATA_W-1-k] = p15_d[14] ^ p15_d[13];
         p15_d           = {p15_d[13:0], w15[DATA_W-1-k]};
      end
      p7_d  = step ? p7_d : p7_q;
      p15_d = step ? p15_d : p15_q;
   end

   // On start the generator emits its first word; on accept it advances from the raw (uncorrupted) word.
   always_comb begin
      m       = go ? mode : mode_q;
      nxt     = m == 3'd1 ? w7
              : m == 3'd2 ? w15
              : m == 3'd3 ? (go ? DATA_W'(1) : {data_q[DATA_W-2:0], data_q[DATA_W-1]})
              : m == 3'd4 ? (go ? fixed_val : fix_q)
              : (go ? '0 : data_q + DATA_W'(1));
      data_d  = step ? nxt : data_q;
      mode_d  = m;
      fix_d   = go ? fixed_val : fix_q;
      len_d   = go ? burst_len : len_q;
      cnt_d   = go ? '0 : (acc && !(&cnt_q)) ? cnt_q + LEN_W'(1) : cnt_q;
      err_d   = inject_err || (err_q && !acc);
      state_d = go ? RUN
              : state_q == DONE ? IDLE
              : !run ? state_q
              : stop ? IDLE
              : (acc && len_q != '0 && cnt_q == len_q - LEN_W'(1)) ? DONE
              : RUN;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         data_q  <= '0;
         fix_q   <= '0;
         p7_q    <= PRBS7_SEED;
         p15_q   <= PRBS15_SEED;
         len_q   <= '0;
         cnt_q   <= '0;
         mode_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         fix_q   <= fix_d;
         p7_q    <= p7_d;
         p15_q   <= p15_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
         err_q   <= err_d;
      end
   end

   assign out_data  = data_q ^ {{(DATA_W-1){1'b0}}, err_q && run};
   assign out_valid = run;
   assign busy      = run;
   assign done      = state_q == DONE;
   assign word_cnt  = cnt_q;
endmodule
